// File: rtl/adc_ltc2308_ctrl.sv
// LTC2308 serial ADC frame controller: CONVST pulse, conversion wait, 12-bit SCK shift
// with config word out on SDI and result in on SDO. Results lag their config by one frame.
module adc_ltc2308_ctrl #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned CONV_CYCLES = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        auto_run,
    input  logic [2:0]  channel,
    output logic        busy,
    output logic        done,
    output logic [11:0] data,
    output logic [2:0]  data_channel,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DIV_W    = 8;
    localparam int unsigned DATA_W   = 12;
    localparam int unsigned BIT_W    = 4;
    localparam int unsigned CH_W     = 3;
    localparam int unsigned CFG_BITS = 6;

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] CFG_END   = BIT_W'(CFG_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CH_W-1:0]     ch_cur_q, ch_cur_d;
    logic [CH_W-1:0]     ch_prev_q, ch_prev_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]     data_channel_q, data_channel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                convst_q, convst_d;
    logic                sck_q, sck_d;
    logic                sdi_q, sdi_d;

    logic [CFG_BITS-1:0] cfg_c;
    logic [2:0]          cfg_idx_c;

    // S/D, O/S, S1, S0, UNI, SLP
    assign cfg_c     = {1'b1, ch_cur_q[0], ch_cur_q[2], ch_cur_q[1], 1'b1, 1'b0};
    assign cfg_idx_c = 3'd5 - bit_q[2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            div_q          <= '0;
            phase_q        <= 1'b0;
            bit_q          <= '0;
            ch_cur_q       <= '0;
            ch_prev_q      <= '0;
            rx_q           <= '0;
            data_q         <= '0;
            data_channel_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            convst_q       <= 1'b0;
            sck_q          <= 1'b0;
            sdi_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            div_q          <= div_d;
            phase_q        <= phase_d;
            bit_q          <= bit_d;
            ch_cur_q       <= ch_cur_d;
            ch_prev_q      <= ch_prev_d;
            rx_q           <= rx_d;
            data_q         <= data_d;
            data_channel_q <= data_channel_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            convst_q       <= convst_d;
            sck_q          <= sck_d;
            sdi_q          <= sdi_d;
        end
    end

    // Pins are registered from the current state, so they trail the state by one clk.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        div_d          = div_q;
        phase_d        = phase_q;
        bit_d          = bit_q;
        ch_cur_d       = ch_cur_q;
        ch_prev_d      = ch_prev_q;
        rx_d           = rx_q;
        data_d         = data_q;
        data_channel_d = data_channel_q;
        done_d         = 1'b0;
        convst_d       = (state_q == S_CONV);
        sck_d          = (state_q == S_SHIFT) && phase_q;
        sdi_d          = (state_q == S_SHIFT) && (bit_q < CFG_END) && cfg_c[cfg_idx_c];

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CONV;
                    cnt_d    = '0;
                    ch_cur_d = channel;
                end
            end
            S_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                // First high-phase cycle is the edge that raises SCK: capture SDO there.
                if (phase_q && (div_q == '0)) begin
                    rx_d = {rx_q[DATA_W-2:0], adc_sdo};
                end
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (phase_q) begin
                        phase_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                done_d         = 1'b1;
                data_d         = rx_q;
                data_channel_d = ch_prev_q;
                ch_prev_d      = ch_cur_q;
                if (auto_run) begin
                    state_d  = S_CONV;
                    cnt_d    = '0;
                    ch_cur_d = channel;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign data         = data_q;
    assign data_channel = data_channel_q;
    assign adc_convst   = convst_q;
    assign adc_sck      = sck_q;
    assign adc_sdi      = sdi_q;

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// Directed bench for adc_ltc2308_ctrl: default-parameter instance plus a
// CLK_DIV=1 / CONV_CYCLES=1 instance, each driven by a small LTC2308 SDO model.
module tb_adc_ltc2308_ctrl;

    localparam int DIV1  = 2;
    localparam int CONV1 = 80;
    localparam int LAT1  = 131;   // 3 + 80 + 24*2
    localparam int LAT2  = 28;    // 3 + 1 + 24*1

    // SDI words (12 bits, first bit MSB) for the channels used
    localparam logic [11:0] SDI_CH3 = 12'hD80;  // 110110 000000
    localparam logic [11:0] SDI_CH5 = 12'hE80;  // 111010 000000
    localparam logic [11:0] SDI_CH2 = 12'h980;  // 100110 000000

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic        start = 1'b0, auto_run = 1'b0;
    logic [2:0]  channel = '0;
    logic        busy, done, adc_convst, adc_sck, adc_sdi, adc_sdo;
    logic [11:0] data;
    logic [2:0]  data_channel;

    logic        start2 = 1'b0;
    logic [2:0]  channel2 = '0;
    logic        busy2, done2, adc_convst2, adc_sck2, adc_sdi2, adc_sdo2;
    logic [11:0] data2;
    logic [2:0]  data_channel2;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    adc_ltc2308_ctrl #(.CLK_DIV(DIV1), .CONV_CYCLES(CONV1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .auto_run(auto_run),
        .channel(channel), .busy(busy), .done(done), .data(data),
        .data_channel(data_channel), .adc_convst(adc_convst), .adc_sck(adc_sck),
        .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
    );

    adc_ltc2308_ctrl #(.CLK_DIV(1), .CONV_CYCLES(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .auto_run(1'b0),
        .channel(channel2), .busy(busy2), .done(done2), .data(data2),
        .data_channel(data_channel2), .adc_convst(adc_convst2), .adc_sck(adc_sck2),
        .adc_sdi(adc_sdi2), .adc_sdo(adc_sdo2)
    );

    // LTC2308 SDO model: loads a word on CONVST rise, advances one bit after each SCK rise
    logic [11:0] model_word = '0, shreg = '0, model_word2 = '0, shreg2 = '0;
    logic        sck_prev = 1'b0, cv_prev = 1'b0, sck_prev2 = 1'b0, cv_prev2 = 1'b0;

    always @(posedge clk) begin
        sck_prev  <= adc_sck;
        cv_prev   <= adc_convst;
        sck_prev2 <= adc_sck2;
        cv_prev2  <= adc_convst2;
        if (adc_convst && !cv_prev)      shreg <= model_word;
        else if (adc_sck && !sck_prev)   shreg <= {shreg[10:0], 1'b0};
        if (adc_convst2 && !cv_prev2)    shreg2 <= model_word2;
        else if (adc_sck2 && !sck_prev2) shreg2 <= {shreg2[10:0], 1'b0};
    end

    assign adc_sdo  = shreg[11];
    assign adc_sdo2 = shreg2[11];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One frame on the default instance, with pin-level waveform checks.
    task automatic run_frame(input logic [2:0] ch, input logic [11:0] word,
                             input logic [2:0] exp_dch, input logic [11:0] exp_sdi,
                             input bit inject);
        logic cv [0:511];
        logic sk [0:511];
        logic sd [0:511];
        int n, conv_hi, first_hi, pulses, width_err, run, busy_hits;
        logic prev;
        logic [11:0] sdi_word, got_data;
        logic [2:0]  got_dch;
        @(negedge clk);
        channel = ch; model_word = word; start = 1'b1;
        @(posedge clk);
        n = 0;
        got_data = '0; got_dch = '0;
        while (n < 500) begin
            @(negedge clk);
            start   = inject && (n == 40 || n == 100);
            channel = start ? ~ch : ch;
            cv[n] = adc_convst; sk[n] = adc_sck; sd[n] = adc_sdi;
            if (done) begin
                got_data = data; got_dch = data_channel;
                break;
            end
            n++;
        end
        start = 1'b0;
        check("latency", 32'(n), 32'(LAT1));
        if (n >= 500) return;
        conv_hi = 0; first_hi = -1; pulses = 0; sdi_word = '0;
        for (int k = 0; k <= n; k++) begin
            if (cv[k]) conv_hi++;
            if (sk[k] && (k == 0 || !sk[k-1])) begin
                pulses++;
                sdi_word = {sdi_word[10:0], sd[k]};
                if (first_hi < 0) first_hi = k;
            end
        end
        check("convst_high", 32'(conv_hi), 32'd2);
        check("convst_low_wait", 32'(first_hi - 3 - DIV1), 32'(CONV1));
        check("sck_pulses", 32'(pulses), 32'd12);
        width_err = 0; run = 0; prev = 1'b1;
        if (first_hi >= 0) begin
            for (int k = first_hi; k <= n; k++) begin
                if (sk[k] == prev) run++;
                else begin
                    if (run != DIV1) width_err++;
                    prev = sk[k]; run = 1;
                end
            end
        end
        check("sck_phase_width", 32'(width_err), 32'd0);
        check("sdi_word", 32'(sdi_word), 32'(exp_sdi));
        check("data", 32'(got_data), 32'(word));
        check("data_channel", 32'(got_dch), 32'(exp_dch));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        busy_hits = 0;
        repeat (20) begin
            if (busy || adc_convst || adc_sck || adc_sdi) busy_hits++;
            @(negedge clk);
        end
        check("idle_after_frame", 32'(busy_hits), 32'd0);
    endtask

    task automatic run_frame2(input logic [2:0] ch, input logic [11:0] word,
                              input logic [2:0] exp_dch);
        int n;
        logic [11:0] got_data;
        logic [2:0]  got_dch;
        @(negedge clk);
        channel2 = ch; model_word2 = word; start2 = 1'b1;
        @(posedge clk);
        n = 0; got_data = '0; got_dch = '0;
        while (n < 200) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2) begin
                got_data = data2; got_dch = data_channel2;
                break;
            end
            n++;
        end
        check("c2_latency", 32'(n), 32'(LAT2));
        check("c2_data", 32'(got_data), 32'(word));
        check("c2_data_channel", 32'(got_dch), 32'(exp_dch));
        @(negedge clk);
        check("c2_done_one_cycle", 32'(done2), 32'd0);
    endtask

    initial begin : main
        int n, k, busy_low, done_cnt;
        int dt [0:3];
        logic [2:0]  dch [0:3];
        logic [11:0] ddat [0:3];

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({busy, done, adc_convst, adc_sck, adc_sdi, data, data_channel}), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_outputs", 32'({busy, done, adc_convst, adc_sck, adc_sdi, data, data_channel}), 32'd0);

        // Single frames; results carry the previous frame's channel
        run_frame(3'd3, 12'h3C1, 3'd0, SDI_CH3, 1'b0);
        run_frame(3'd5, 12'hA5C, 3'd3, SDI_CH5, 1'b0);
        // Starts during WAIT and SHIFT must not restart or rechannel the frame
        run_frame(3'd2, 12'h5A3, 3'd5, SDI_CH2, 1'b1);

        // Back-to-back frames with auto_run; dropped after the third done
        @(negedge clk);
        auto_run = 1'b1; channel = 3'd7; model_word = 12'h7E1; start = 1'b1;
        @(posedge clk);
        n = 0; k = 0; busy_low = 0;
        for (int i = 0; i < 4; i++) begin dt[i] = 0; dch[i] = '0; ddat[i] = '0; end
        while (n < 1000 && k < 4) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dt[k] = n; dch[k] = data_channel; ddat[k] = data;
                k++;
                if (k == 3) auto_run = 1'b0;
            end
            if (k < 4 && !busy) busy_low++;
            n++;
        end
        check("auto_done_count", 32'(k), 32'd4);
        check("auto_first_latency", 32'(dt[0]), 32'(LAT1));
        check("auto_period_1", 32'(dt[1] - dt[0]), 32'(LAT1));
        check("auto_period_2", 32'(dt[2] - dt[1]), 32'(LAT1));
        check("auto_period_3", 32'(dt[3] - dt[2]), 32'(LAT1));
        check("auto_busy_low", 32'(busy_low), 32'd0);
        check("auto_dch_first", 32'(dch[0]), 32'd2);
        check("auto_dch_next", 32'(dch[1]), 32'd7);
        check("auto_data", 32'(ddat[2]), 32'h7E1);
        repeat (10) @(negedge clk);
        check("auto_stopped", 32'({busy, adc_convst}), 32'd0);

        // Reset mid-SHIFT aborts the frame
        @(negedge clk);
        channel = 3'd4; model_word = 12'h111; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_shifting", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_frame", 32'({busy, done, adc_convst, adc_sck, adc_sdi, data, data_channel}), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        done_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("no_done_after_abort", 32'(done_cnt), 32'd0);
        check("data_after_abort", 32'(data), 32'd0);
        run_frame(3'd3, 12'h0F0, 3'd0, SDI_CH3, 1'b0);

        // Minimum-parameter instance: full-scale and LSB-only results
        run_frame2(3'd1, 12'hFFF, 3'd0);
        run_frame2(3'd6, 12'h001, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
